// File: rtl/red_pkg.sv
// Shared definitions for the RED sequencer: FSM state type and datapath widths.
package red_pkg;

  localparam int unsigned NIB_W       = 4;
  localparam int unsigned LANE_W      = 5;
  localparam int unsigned PAIR_W      = 6;
  localparam int unsigned RED_LAT     = 7;
  localparam int unsigned RED_LAT_PAR = 4;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    TREE1,
    TREE2,
    DONE
  } red_state_t;

endpackage

// File: rtl/red_lane_add.sv
// Combinational signed nibble adder: sext(i_a) + sext(i_b), one bit wider than
// the inputs so the result cannot overflow.
// Ports:
//   i_a, i_b : signed NIB_W-bit nibbles
//   o_sum    : signed LANE_W-bit sum
module red_lane_add
  import red_pkg::*;
(
  input  logic [NIB_W-1:0]  i_a,
  input  logic [NIB_W-1:0]  i_b,
  output logic [LANE_W-1:0] o_sum
);

  assign o_sum = {i_a[NIB_W-1], i_a} + {i_b[NIB_W-1], i_b};

endmodule

// File: rtl/red_seq_ctrl.sv
// Multi-cycle sequencer for the RED nibble-reduction operation:
//   S = sext((A3+B3)+(A2+B2)) + ((A1+B1)+(A0+B0)), all nibbles signed.
// A shared lane adder walks the four nibble pairs (SUM, 4 cycles), then a
// two-step tree (TREE1, TREE2) reduces the lanes; DONE presents the result.
// Build option: RED_SEQ_PARALLEL_EN instantiates four lane adders so SUM
// takes a single cycle.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : op request, honoured only while ready=1
//   flush       : synchronous abort, wins over start
//   A, B        : operands, captured on the accepted start
//   ready       : can accept start (IDLE, DONE)
//   busy        : op in flight (SUM, TREE1, TREE2)
//   valid       : one-cycle pulse, S is new
//   S           : result, held until the next valid
module red_seq_ctrl #(
  parameter int unsigned NIB_W   = 4,
  parameter int unsigned NUM_NIB = 4,
  parameter int unsigned OUT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     flush,
  input  logic [NUM_NIB*NIB_W-1:0] A,
  input  logic [NUM_NIB*NIB_W-1:0] B,
  output logic                     ready,
  output logic                     busy,
  output logic                     valid,
  output logic [OUT_W-1:0]         S
);

  import red_pkg::*;

  red_state_t r_state;
  red_state_t w_next;

  logic [NUM_NIB*NIB_W-1:0] r_opA;
  logic [NUM_NIB*NIB_W-1:0] r_opB;
  logic [LANE_W-1:0]        r_lane [NUM_NIB];
  logic [PAIR_W-1:0]        r_p_hi;
  logic [PAIR_W-1:0]        r_p_lo;
  logic [OUT_W-1:0]         r_S;
  logic                     w_accept;

`ifdef RED_SEQ_PARALLEL_EN
  logic [LANE_W-1:0] w_lane_par [NUM_NIB];

  for (genvar gi = 0; gi < NUM_NIB; gi++) begin : g_lane
    red_lane_add u_lane_add (
      .i_a   (r_opA[gi*NIB_W +: NIB_W]),
      .i_b   (r_opB[gi*NIB_W +: NIB_W]),
      .o_sum (w_lane_par[gi])
    );
  end
`else
  logic [1:0]        r_cnt;
  logic [LANE_W-1:0] w_lane;

  // Shared adder is steered to nibble pair r_cnt.
  red_lane_add u_lane_add (
    .i_a   (r_opA[{r_cnt, 2'b00} +: NIB_W]),
    .i_b   (r_opB[{r_cnt, 2'b00} +: NIB_W]),
    .o_sum (w_lane)
  );
`endif

  assign w_accept = ready && start && !flush;
  assign S        = r_S;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    valid  = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_next = SUM;
      end
      SUM: begin
        busy = 1'b1;
`ifdef RED_SEQ_PARALLEL_EN
        w_next = TREE1;
`else
        if (r_cnt == 2'd3) w_next = TREE1;
`endif
      end
      TREE1: begin
        busy   = 1'b1;
        w_next = TREE2;
      end
      TREE2: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        ready  = 1'b1;
        valid  = 1'b1;
        w_next = start ? SUM : IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  // Datapath is frozen under flush, so an aborted op never touches S.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opA  <= '0;
      r_opB  <= '0;
      r_p_hi <= '0;
      r_p_lo <= '0;
      r_S    <= '0;
      for (int unsigned i = 0; i < NUM_NIB; i++) r_lane[i] <= '0;
`ifndef RED_SEQ_PARALLEL_EN
      r_cnt  <= '0;
`endif
    end else if (!flush) begin
      if (w_accept) begin
        r_opA <= A;
        r_opB <= B;
`ifndef RED_SEQ_PARALLEL_EN
        r_cnt <= '0;
`endif
      end
      case (r_state)
        SUM: begin
`ifdef RED_SEQ_PARALLEL_EN
          r_lane <= w_lane_par;
`else
          r_lane[r_cnt] <= w_lane;
          r_cnt         <= r_cnt + 2'd1;
`endif
        end
        TREE1: begin
          r_p_hi <= {r_lane[3][LANE_W-1], r_lane[3]} + {r_lane[2][LANE_W-1], r_lane[2]};
          r_p_lo <= {r_lane[1][LANE_W-1], r_lane[1]} + {r_lane[0][LANE_W-1], r_lane[0]};
        end
        TREE2: begin
          r_S <= {{(OUT_W-PAIR_W){r_p_hi[PAIR_W-1]}}, r_p_hi}
               + {{(OUT_W-PAIR_W){r_p_lo[PAIR_W-1]}}, r_p_lo};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Self-checking bench for red_seq_ctrl: directed cases, flush/reset/ignore
// scenarios and randomized ops against an arithmetic reference model.
module tb_red_seq_ctrl;

`ifdef RED_SEQ_PARALLEL_EN
  localparam int LAT     = 4;
  localparam int FLUSH_N = 1;
`else
  localparam int LAT     = 7;
  localparam int FLUSH_N = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [15:0] A;
  logic [15:0] B;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [15:0] S;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] last_exp;

  red_seq_ctrl #(.NIB_W(4), .NUM_NIB(4), .OUT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .flush (flush),
    .A     (A),
    .B     (B),
    .ready (ready),
    .busy  (busy),
    .valid (valid),
    .S     (S)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Sum of all eight signed nibbles, computed with plain integers.
  function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
    int s;
    int va;
    int vb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      va = int'((a >> (4 * i)) & 16'hF);
      vb = int'((b >> (4 * i)) & 16'hF);
      if (va >= 8) va -= 16;
      if (vb >= 8) vb -= 16;
      s += va + vb;
    end
    return s[15:0];
  endfunction

  // Issue one op (caller guarantees ready), optionally pulse a stray start at
  // cycle intr, and check latency plus result.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int intr,
                       input bit dir, input string tag);
    logic [15:0] exp_s;
    int n;
    exp_s = ref_red(a, b);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0; A = 16'($urandom); B = 16'($urandom);
    n = 1;
    while (!valid && n < 30) begin
      if (dir) begin
        check({tag, "_ready_low"}, 32'(ready), 32'd0);
        check({tag, "_busy_or_ready"}, 32'(busy | ready), 32'd1);
      end
      if (n == intr) begin
        start = 1'b1; A = 16'($urandom); B = 16'($urandom);
      end
      tick();
      start = 1'b0;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check({tag, "_S"}, 32'(S), 32'(exp_s));
    last_exp = exp_s;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_valid;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; A = '0; B = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_S",     32'(S),     32'h0);

    do_op(16'h8888, 16'h8888, 0, 1'b1, "min");
    check("min_valid_pulse", 32'(valid), 32'd1);
    tick();
    check("valid_one_cycle", 32'(valid), 32'd0);
    do_op(16'h9999, 16'h7777, 0, 1'b1, "zero");
    tick();
    do_op(16'h7777, 16'h7777, 0, 1'b1, "max");
    tick();
    do_op(16'h1234, 16'h0000, 0, 1'b1, "mixed");
    // Back-to-back: start issued in the DONE cycle.
    do_op(16'h7777, 16'h7777, 0, 1'b1, "b2b");
    tick();

    // Flush mid-SUM: no valid, S unchanged.
    A = 16'h8888; B = 16'h8888; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (FLUSH_N - 1) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_busy",  32'(busy),  32'd0);
    check("flush_valid", 32'(valid), 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid) seen_valid = 1'b1;
      tick();
    end
    check("flush_no_valid", 32'(seen_valid), 32'd0);
    check("flush_S_kept", 32'(S), 32'(last_exp));

    // Flush together with start in IDLE: start dropped.
    A = 16'h1111; B = 16'h1111; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy",  32'(busy),  32'd0);
    check("flush_start_ready", 32'(ready), 32'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (valid) seen_valid = 1'b1;
      tick();
    end
    check("flush_start_no_valid", 32'(seen_valid), 32'd0);

    // Stray start during TREE1 is ignored.
    do_op(16'h1234, 16'h4321, LAT - 2, 1'b1, "ignore");
    tick();
    check("ignore_no_restart", 32'(busy), 32'd0);

    // Reset asserted during TREE2.
    A = 16'h7777; B = 16'h7777; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LAT - 2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_S",     32'(S),     32'h0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy",  32'(busy),  32'd0);
    last_exp = '0;

    for (int k = 0; k < 2000; k++) begin
      do_op(16'($urandom), 16'($urandom), 0, 1'b0, "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/red_seq_ctrl.md
Name: red_seq_ctrl

Overview:
- Multi-cycle sequencer for the RED (nibble-reduction) operation, for area-constrained Execute builds.
- One shared signed 4+4-bit lane adder is time-multiplexed across the four nibble pairs, followed by a two-step reduction tree.
- Sits beside the ALU in Execute. Decode pulses start; Execute stalls until valid.
- Arithmetic result is identical to the single-cycle RED unit: S = sext((A3+B3)+(A2+B2)) + ((A1+B1)+(A0+B0)), with every nibble treated as signed.

Parameters:
- NIB_W, 4: nibble width. Fixed for this ISA and present for readability only.
- NUM_NIB, 4: nibbles per operand. Fixed.
- OUT_W, 16: result width.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: request a RED op. Sampled only while ready=1.
- flush, input, 1: synchronous abort of any in-flight op.
- A, input, 16: operand A, captured on the accepted start.
- B, input, 16: operand B, captured on the accepted start.
- ready, output, 1: block can accept start this cycle.
- busy, output, 1: op in flight.
- valid, output, 1: one-cycle pulse; S is new this cycle.
- S, output, 16: reduction result, held until the next valid.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-low on rst_n, using the codebase clock and reset names clk/rst_n.
  - Reset values: state=IDLE, ready=1, busy=0, valid=0, S=16'h0000, cnt=0, lane/pair regs=0.
- States: IDLE, SUM, TREE1, TREE2, DONE.
- IDLE:
  - ready=1.
  - On start && !flush: latch A and B into opA/opB, cnt<=0, go to SUM.
- SUM (4 cycles):
  - Each cycle: lane[cnt] <= sext5(opA nibble cnt) + sext5(opB nibble cnt).
  - cnt increments. After cnt==3, go to TREE1.
  - cnt is 2 bits and wraps to 0 after 3.
- TREE1:
  - p_hi <= sext6(lane3)+sext6(lane2).
  - p_lo <= sext6(lane1)+sext6(lane0).
- TREE2:
  - S <= sext16(p_hi)+sext16(p_lo).
  - Go to DONE.
- DONE:
  - valid=1 and ready=1.
  - A start here is accepted; this gives back-to-back ops with no IDLE bubble.
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0 -> valid high in the cycle after edge E6. Throughput is one op per 7 cycles.
- busy=1 in SUM, TREE1 and TREE2. ready=1 only in IDLE and DONE.
- start while ready=0 is ignored and not queued. Operand changes after acceptance have no effect.
- flush:
  - Any state goes to IDLE on the next edge. valid is not pulsed and S keeps its old value.
  - flush and start in the same cycle: flush wins and start is dropped.
- rst_n low mid-op: takes priority over everything. All registers return to their reset values on that edge.
- Widths: 5-bit lanes, 6-bit pairs and a 16-bit sum cannot overflow. The range is -64..+56, so the result always fits in 16 bits.

Optional Feature:
- Macro: RED_SEQ_PARALLEL_EN.
- Defined:
  - Four lane adders are instantiated and SUM computes all lanes in one cycle.
  - Latency drops to valid after E3; the other rules are unchanged.
- Undefined:
  - The single shared lane adder is used with a 4-cycle SUM, as specified above.

Decomposition:
- Package red_pkg holds:
  - red_state_t enum {IDLE, SUM, TREE1, TREE2, DONE}.
  - Constants NIB_W=4, LANE_W=5, PAIR_W=6, RED_LAT=7, RED_LAT_PAR=4.
- Sub-module red_lane_add: combinational signed 4-bit + 4-bit to 5-bit adder. It is instantiated once, or four times when RED_SEQ_PARALLEL_EN is defined.

Test Plan:
- A=16'h8888, B=16'h8888, start one cycle -> valid pulse exactly 7 cycles after acceptance with S=16'hFFC0; ready=0 during cycles 1-6.
- A=16'h9999, B=16'h7777 -> S=16'h0000. A=16'h7777, B=16'h7777 -> S=16'h0038. A=16'h1234, B=16'h0000 -> S=16'h000A.
- Back-to-back: second start in the DONE cycle with A=B=16'h7777 -> second valid 7 cycles later; no cycle with both busy=0 and ready=0 in between.
- Assert flush in SUM at cnt=2 -> IDLE on the next edge, no valid, S keeps the prior value. Also: flush with start in IDLE -> remains IDLE.
- start pulsed during TREE1 with different operands -> ignored; the original result is delivered.
- rst_n low for one cycle during TREE2 -> S=16'h0000, ready=1, valid=0 next cycle. Then 2000 random signed-nibble ops -> compared against a reference model (both with and without RED_SEQ_PARALLEL_EN).
